// File: rtl/ifetch_tag_stage_pkg.sv
// Shared core constants and types for the instruction fetch tag stage.
// Bus layout: {pc, warp_idx}, PC in the MSBs.
package ifetch_tag_stage_pkg;

   localparam int NUM_WARP_PER_CORE        = 4;
   localparam int NUM_WARP_PER_CORE_LOG    = 2;
   localparam int ADDR_WIDTH               = 32;
   localparam int L1_CACHE_LINE_OFFSET_LOG = 6;
   localparam int L1_CACHE_NUM_SETS_LOG    = 6;
   localparam int IFT_TO_IFD_BUS_WIDTH     = ADDR_WIDTH + NUM_WARP_PER_CORE_LOG;

   typedef logic [NUM_WARP_PER_CORE_LOG-1:0] warp_idx_t;
   typedef logic [NUM_WARP_PER_CORE-1:0]     warp_mask_t;
   typedef logic [ADDR_WIDTH-1:0]            addr_t;
   typedef logic [L1_CACHE_NUM_SETS_LOG-1:0] set_idx_t;

   typedef struct packed {
      addr_t     pc;
      warp_idx_t warp_idx;
   } ift_to_ifd_t;

   localparam addr_t PC_STEP = addr_t'(4);

   function automatic set_idx_t pc_to_set_idx(input addr_t pc);
      return pc[L1_CACHE_LINE_OFFSET_LOG +: L1_CACHE_NUM_SETS_LOG];
   endfunction

endpackage

// File: rtl/ift_rr_arbiter.sv
// Round-robin warp arbiter: searches from last_grant+1 with wrap, purely combinational.
// last_grant_nxt carries the pointer the owner should register when upd_en is high.
module ift_rr_arbiter
   import ifetch_tag_stage_pkg::*;
(
   input  warp_mask_t req,
   input  warp_idx_t  last_grant,
   input  logic       upd_en,
   output warp_idx_t  grant_idx,
   output logic       grant_any,
   output warp_idx_t  last_grant_nxt
);

   warp_idx_t cand;

   // First requester after last_grant wins; grant_idx stays 0 when nobody requests.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int i = 1; i <= NUM_WARP_PER_CORE; i++) begin
         cand = warp_idx_t'((int'(last_grant) + i) % NUM_WARP_PER_CORE);
         if (!grant_any && req[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign last_grant_nxt = upd_en ? grant_idx : last_grant;

endmodule

// File: rtl/ifetch_tag_stage.sv
// Instruction fetch tag stage: per-warp PC/sleep state, round-robin warp pick, icache set read.
// Define IFETCH_TAG_ASSERT_EN to compile in simulation assertions.
module ifetch_tag_stage
   import ifetch_tag_stage_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_WARP_PER_CORE-1:0]     warp_en_bitmap,
   input  logic                             ifd_allowin,
   input  logic                             ifd_cache_miss,
   input  logic                             ifd_near_miss,
   input  logic [NUM_WARP_PER_CORE_LOG-1:0] ifd_cache_miss_warp_idx,
   input  logic [NUM_WARP_PER_CORE-1:0]     l2i_to_ift_wake_bitmap,
   input  logic                             wb_rollback_en,
   input  logic [NUM_WARP_PER_CORE_LOG-1:0] wb_rollback_warp_idx,
   input  logic [ADDR_WIDTH-1:0]            wb_rollback_pc,
   output logic                             ift_to_ifd_valid,
   output logic [IFT_TO_IFD_BUS_WIDTH-1:0]  ift_to_ifd_bus,
   output logic                             ift_to_icache_fetch_en,
   output logic [L1_CACHE_NUM_SETS_LOG-1:0] ift_to_icache_fetch_set_idx
);

   addr_t       pc_q [NUM_WARP_PER_CORE];
   addr_t       pc_nxt [NUM_WARP_PER_CORE];
   warp_mask_t  sleep_q;
   warp_mask_t  sleep_nxt;
   warp_idx_t   last_grant_q;
   warp_idx_t   last_grant_nxt;
   addr_t       last_issued_pc_q;

   warp_mask_t  eligible;
   warp_mask_t  miss_hit;
   warp_mask_t  rb_hit;
   warp_idx_t   grant_idx;
   logic        grant_any;
   logic        miss_or_near;
   logic        transfer;
   addr_t       grant_pc;
   ift_to_ifd_t bus;

   assign miss_or_near = ifd_cache_miss | ifd_near_miss;

   // Warps being restored or redirected this cycle are masked so their stale PC is never issued.
   // Gating with rst_n keeps valid low and the bus on warp 0 while reset is held.
   always_comb begin
      eligible = '0;
      miss_hit = '0;
      rb_hit   = '0;
      for (int w = 0; w < NUM_WARP_PER_CORE; w++) begin
         miss_hit[w] = miss_or_near && (ifd_cache_miss_warp_idx == warp_idx_t'(w));
         rb_hit[w]   = wb_rollback_en && (wb_rollback_warp_idx == warp_idx_t'(w));
         eligible[w] = rst_n & warp_en_bitmap[w] & ~sleep_q[w] & ~miss_hit[w] & ~rb_hit[w];
      end
   end

   ift_rr_arbiter u_arb (
      .req            (eligible),
      .last_grant     (last_grant_q),
      .upd_en         (transfer),
      .grant_idx      (grant_idx),
      .grant_any      (grant_any),
      .last_grant_nxt (last_grant_nxt)
   );

   // Handshake: a fetch moves to the data stage in any cycle where ift_to_ifd_valid and
   // ifd_allowin are both high; valid is recomputed each cycle from eligibility and may drop
   // without a transfer (enable cleared, miss, rollback), in which case no state moves.
   assign transfer = grant_any & ifd_allowin;
   assign grant_pc = pc_q[grant_idx];

   assign bus.pc       = grant_pc;
   assign bus.warp_idx = grant_idx;

   assign ift_to_ifd_valid            = grant_any;
   assign ift_to_ifd_bus              = bus;
   assign ift_to_icache_fetch_en      = transfer;
   assign ift_to_icache_fetch_set_idx = pc_to_set_idx(grant_pc);

   // Per-warp PC priority: writeback redirect, then miss restore, then fetch increment.
   always_comb begin
      for (int w = 0; w < NUM_WARP_PER_CORE; w++) begin
         pc_nxt[w] = pc_q[w];
         if (rb_hit[w])
            pc_nxt[w] = wb_rollback_pc;
         else if (miss_hit[w])
            pc_nxt[w] = last_issued_pc_q;
         else if (transfer && (grant_idx == warp_idx_t'(w)))
            pc_nxt[w] = pc_q[w] + PC_STEP;
      end
   end

   // Only a real miss sleeps the warp; a wake in the same cycle wins.
   always_comb begin
      sleep_nxt = (sleep_q | (miss_hit & {NUM_WARP_PER_CORE{ifd_cache_miss}}))
                  & ~l2i_to_ift_wake_bitmap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < NUM_WARP_PER_CORE; w++)
            pc_q[w] <= '0;
         sleep_q          <= '0;
         last_grant_q     <= warp_idx_t'(NUM_WARP_PER_CORE - 1);
         last_issued_pc_q <= '0;
      end else begin
         for (int w = 0; w < NUM_WARP_PER_CORE; w++)
            pc_q[w] <= pc_nxt[w];
         sleep_q      <= sleep_nxt;
         last_grant_q <= last_grant_nxt;
         if (transfer)
            last_issued_pc_q <= grant_pc;
      end
   end

`ifdef IFETCH_TAG_ASSERT_EN
   warp_mask_t grant_onehot;
   assign grant_onehot = warp_mask_t'(1) << grant_idx;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (ift_to_ifd_valid)
            assert ($onehot(grant_onehot & eligible))
               else $error("ift: grant not one-hot/eligible");
         assert (!(ifd_cache_miss && ifd_near_miss))
            else $error("ift: miss and near miss together");
         if (ifd_cache_miss)
            assert (!sleep_q[ifd_cache_miss_warp_idx])
               else $error("ift: miss on sleeping warp");
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_tag_stage.sv
// Directed bench for ifetch_tag_stage: hand-computed fetch order, PCs and set indices.
module tb_ifetch_tag_stage;
   import ifetch_tag_stage_pkg::*;

   logic                             clk;
   logic                             rst_n;
   logic [NUM_WARP_PER_CORE-1:0]     warp_en_bitmap;
   logic                             ifd_allowin;
   logic                             ifd_cache_miss;
   logic                             ifd_near_miss;
   logic [NUM_WARP_PER_CORE_LOG-1:0] ifd_cache_miss_warp_idx;
   logic [NUM_WARP_PER_CORE-1:0]     l2i_to_ift_wake_bitmap;
   logic                             wb_rollback_en;
   logic [NUM_WARP_PER_CORE_LOG-1:0] wb_rollback_warp_idx;
   logic [ADDR_WIDTH-1:0]            wb_rollback_pc;
   logic                             ift_to_ifd_valid;
   logic [IFT_TO_IFD_BUS_WIDTH-1:0]  ift_to_ifd_bus;
   logic                             ift_to_icache_fetch_en;
   logic [L1_CACHE_NUM_SETS_LOG-1:0] ift_to_icache_fetch_set_idx;

   int n_cmp = 0;
   int n_err = 0;

   ifetch_tag_stage dut (
      .clk                         (clk),
      .rst_n                       (rst_n),
      .warp_en_bitmap              (warp_en_bitmap),
      .ifd_allowin                 (ifd_allowin),
      .ifd_cache_miss              (ifd_cache_miss),
      .ifd_near_miss               (ifd_near_miss),
      .ifd_cache_miss_warp_idx     (ifd_cache_miss_warp_idx),
      .l2i_to_ift_wake_bitmap      (l2i_to_ift_wake_bitmap),
      .wb_rollback_en              (wb_rollback_en),
      .wb_rollback_warp_idx        (wb_rollback_warp_idx),
      .wb_rollback_pc              (wb_rollback_pc),
      .ift_to_ifd_valid            (ift_to_ifd_valid),
      .ift_to_ifd_bus              (ift_to_ifd_bus),
      .ift_to_icache_fetch_en      (ift_to_icache_fetch_en),
      .ift_to_icache_fetch_set_idx (ift_to_icache_fetch_set_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Expects a transferring fetch of warp idx at pc (allowin assumed high).
   task automatic fetch_chk(input string tag, input logic [31:0] pc, input logic [1:0] idx);
      logic [33:0] exp_bus;
      logic [5:0]  exp_set;
      exp_bus = {pc, idx};
      exp_set = pc[11:6];
      settle();
      chk({tag, "_valid"}, 64'(ift_to_ifd_valid), 64'd1);
      chk({tag, "_bus"}, 64'(ift_to_ifd_bus), 64'(exp_bus));
      chk({tag, "_fetch_en"}, 64'(ift_to_icache_fetch_en), 64'd1);
      chk({tag, "_set_idx"}, 64'(ift_to_icache_fetch_set_idx), 64'(exp_set));
      next_cycle();
   endtask

   task automatic idle_chk(input string tag);
      settle();
      chk({tag, "_valid"}, 64'(ift_to_ifd_valid), 64'd0);
      chk({tag, "_fetch_en"}, 64'(ift_to_icache_fetch_en), 64'd0);
      next_cycle();
   endtask

   initial begin
      rst_n                   = 1'b0;
      warp_en_bitmap          = 4'b1111;
      ifd_allowin             = 1'b1;
      ifd_cache_miss          = 1'b0;
      ifd_near_miss           = 1'b0;
      ifd_cache_miss_warp_idx = 2'd0;
      l2i_to_ift_wake_bitmap  = 4'b0000;
      wb_rollback_en          = 1'b0;
      wb_rollback_warp_idx    = 2'd0;
      wb_rollback_pc          = 32'h0;

      #3;
      chk("rst_valid", 64'(ift_to_ifd_valid), 64'd0);
      chk("rst_fetch_en", 64'(ift_to_icache_fetch_en), 64'd0);
      chk("rst_bus", 64'(ift_to_ifd_bus), 64'd0);
      chk("rst_set_idx", 64'(ift_to_icache_fetch_set_idx), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n          = 1'b1;
      warp_en_bitmap = 4'b0001;

      // single warp streaming
      fetch_chk("t1_f0", 32'h0, 2'd0);
      fetch_chk("t1_f1", 32'h4, 2'd0);

      // enable dropped for one cycle, then resumes without skipping
      warp_en_bitmap = 4'b0000;
      idle_chk("drop");
      warp_en_bitmap = 4'b0001;
      fetch_chk("t1_f2", 32'h8, 2'd0);

      // miss on warp 0 (fetch 0x8 is in the data stage)
      ifd_cache_miss = 1'b1;
      ifd_cache_miss_warp_idx = 2'd0;
      idle_chk("miss_cyc");
      ifd_cache_miss = 1'b0;
      idle_chk("sleeping");
      l2i_to_ift_wake_bitmap = 4'b0001;
      idle_chk("wake_cyc");
      l2i_to_ift_wake_bitmap = 4'b0000;
      fetch_chk("woke_f0", 32'h8, 2'd0);
      fetch_chk("woke_f1", 32'hc, 2'd0);

      // round robin across warps
      warp_en_bitmap = 4'b0011;
      fetch_chk("rr_w1a", 32'h0, 2'd1);
      fetch_chk("rr_w0a", 32'h10, 2'd0);
      fetch_chk("rr_w1b", 32'h4, 2'd1);
      warp_en_bitmap = 4'b1111;
      fetch_chk("rr_w2", 32'h0, 2'd2);
      fetch_chk("rr_w3", 32'h0, 2'd3);
      fetch_chk("rr_w0b", 32'h14, 2'd0);

      // writeback rollback of warp 1 to 0x100
      wb_rollback_en       = 1'b1;
      wb_rollback_warp_idx = 2'd1;
      wb_rollback_pc       = 32'h100;
      fetch_chk("rb_skip_w2", 32'h4, 2'd2);
      wb_rollback_en = 1'b0;
      fetch_chk("rb_w3", 32'h4, 2'd3);
      fetch_chk("rb_w0", 32'h18, 2'd0);
      fetch_chk("rb_w1", 32'h100, 2'd1);

      // near miss on warp 0: restore PC, no sleep, no wake needed
      warp_en_bitmap = 4'b0001;
      fetch_chk("nm_pre", 32'h1c, 2'd0);
      ifd_near_miss = 1'b1;
      ifd_cache_miss_warp_idx = 2'd0;
      idle_chk("nm_cyc");
      ifd_near_miss = 1'b0;
      fetch_chk("nm_refetch", 32'h1c, 2'd0);
      fetch_chk("nm_next", 32'h20, 2'd0);

      // miss and wake of the same warp in the same cycle: stays awake
      ifd_cache_miss = 1'b1;
      l2i_to_ift_wake_bitmap = 4'b0001;
      idle_chk("mw_cyc");
      ifd_cache_miss = 1'b0;
      l2i_to_ift_wake_bitmap = 4'b0000;
      fetch_chk("mw_refetch", 32'h20, 2'd0);

      // data stage stalled: presented but not transferred, state holds
      ifd_allowin = 1'b0;
      settle();
      chk("stall_valid", 64'(ift_to_ifd_valid), 64'd1);
      chk("stall_fetch_en", 64'(ift_to_icache_fetch_en), 64'd0);
      chk("stall_bus", 64'(ift_to_ifd_bus), 64'({32'h24, 2'd0}));
      next_cycle();
      ifd_allowin = 1'b1;
      fetch_chk("stall_resume", 32'h24, 2'd0);

      // rollback to top of address space: last set index, then 32-bit wrap
      wb_rollback_en       = 1'b1;
      wb_rollback_warp_idx = 2'd0;
      wb_rollback_pc       = 32'hffff_fffc;
      idle_chk("rb_top_cyc");
      wb_rollback_en = 1'b0;
      fetch_chk("top_pc", 32'hffff_fffc, 2'd0);
      fetch_chk("wrap_pc", 32'h0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
